// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding and the default operand width.
package serial_mag_comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Beat/verdict bundle for the serial comparator. The driver of operand beats
// uses the master view; the comparator itself uses the slave view.
interface serial_mag_comparator_if;

  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic g;
  logic e;
  logic l;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, g, e, l
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, g, e, l
  );

endinterface

// File: rtl/serial_mag_comparator_bit_cmp_cell.sv
// Combinational 1-bit greater/equal/less cell. Exactly one output is high
// for any input pair.
module bit_cmp_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_gt,
  output logic o_eq,
  output logic o_lt
);

  assign o_gt = i_a & ~i_b;
  assign o_eq = ~(i_a ^ i_b);
  assign o_lt = ~i_a & i_b;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator. Operand bits arrive MSB first,
// one pair per accepted beat; the first differing bit pair decides the
// verdict, which then stays sticky until the next start or reset.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mag_comparator_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_g;
  logic             r_e;
  logic             r_l;
  logic             w_g_nxt;
  logic             w_e_nxt;
  logic             w_l_nxt;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_last;

  bit_cmp_cell u_cell (
    .i_a  (bus.a_bit),
    .i_b  (bus.b_bit),
    .o_gt (w_gt),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  // Register all state and outputs so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g     <= 1'b0;
      r_e     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_g     <= w_g_nxt;
      r_e     <= w_e_nxt;
      r_l     <= w_l_nxt;
    end
  end

  // Next-state, beat counting and sticky verdict update; e acts as "still undecided".
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_g_nxt     = r_g;
    w_e_nxt     = r_e;
    w_l_nxt     = r_l;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_COMPARE;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_g_nxt     = 1'b0;
          w_e_nxt     = 1'b1;
          w_l_nxt     = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        w_busy_nxt = 1'b1;
        if (bus.bit_valid) begin
          w_count_nxt = r_count + CNT_W'(1);
          w_g_nxt     = r_g | (r_e & w_gt);
          w_l_nxt     = r_l | (r_e & w_lt);
          w_e_nxt     = r_e & w_eq;
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.g    = r_g;
  assign bus.e    = r_e;
  assign bus.l    = r_l;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for the serial comparator: the driver pushes the expected
// verdict and completion cycle for each comparison it launches, and an
// independent monitor checks them whenever done pulses.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  typedef struct {
    logic [2:0] gel;
    int         doneCycle;
    bit         followStart;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycleCount;
  int   checks;
  int   errors;
  exp_t sbq[$];
  bit         postPending;
  bit         postFollow;
  logic [2:0] postGel;

  serial_mag_comparator_if bus ();

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time done against the model's expected latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  // Idle cycles with random noise on the beat lines, which the DUT must ignore.
  task automatic idleGap(input int n);
    for (int k = 0; k < n; k++) begin
      bus.start     = 1'b0;
      bus.bit_valid = 1'($urandom);
      bus.a_bit     = 1'($urandom);
      bus.b_bit     = 1'($urandom);
      @(posedge clk) #1;
    end
    bus.bit_valid = 1'b0;
  endtask

  // Launch one comparison; called 1ns after a rising edge, returns likewise
  // right after the edge that consumes the last beat.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int stallAt, input int stallLen,
                               input bit backToBack, input bit startNoise);
    exp_t x;
    int   stalls;
    stalls        = (stallAt > 0 && stallAt < WIDTH) ? stallLen : 0;
    x.gel         = {a > b, a == b, a < b};
    x.doneCycle   = cycleCount + 1 + WIDTH + stalls;
    x.followStart = 1'b0;
    if (backToBack && sbq.size() > 0) sbq[sbq.size()-1].followStart = 1'b1;
    sbq.push_back(x);
    bus.start     = 1'b1;
    bus.bit_valid = 1'($urandom);
    bus.a_bit     = 1'($urandom);
    bus.b_bit     = 1'($urandom);
    @(posedge clk) #1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      bus.bit_valid = 1'b1;
      bus.a_bit     = a[i];
      bus.b_bit     = b[i];
      bus.start     = (startNoise && i == WIDTH - 3) ? 1'b1 : 1'b0;
      @(posedge clk) #1;
      if (startNoise && i == WIDTH - 3) checkOutput("busy_after_ignored_start", 32'(bus.busy), 32'd1);
      if (stalls > 0 && (WIDTH - i) == stallAt) begin
        for (int s = 0; s < stalls; s++) begin
          bus.start     = 1'b0;
          bus.bit_valid = 1'b0;
          bus.a_bit     = 1'($urandom);
          bus.b_bit     = 1'($urandom);
          @(posedge clk) #1;
        end
      end
    end
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare,
  // then check the cycle after done (verdict held, or cleared by a new start).
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      postPending = 1'b0;
    end else begin
      if (postPending) begin
        postPending = 1'b0;
        checkOutput("post_done_pulse", 32'(bus.done), 32'd0);
        if (postFollow) begin
          checkOutput("post_restart_busy", 32'(bus.busy), 32'd1);
          checkOutput("post_restart_gel", 32'({bus.g, bus.e, bus.l}), 32'b010);
        end else begin
          checkOutput("post_idle_busy", 32'(bus.busy), 32'd0);
          checkOutput("post_idle_gel_held", 32'({bus.g, bus.e, bus.l}), 32'(postGel));
        end
      end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          x = sbq.pop_front();
          checkOutput("verdict_gel", 32'({bus.g, bus.e, bus.l}), 32'(x.gel));
          checkOutput("done_cycle", 32'(cycleCount), 32'(x.doneCycle));
          checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
          postPending = 1'b1;
          postFollow  = x.followStart;
          postGel     = x.gel;
        end
      end
    end
  end

  // Directed scenarios, then randomized comparisons, then a bounded drain.
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit               b2b;
    checks        = 0;
    errors        = 0;
    cycleCount    = 0;
    postPending   = 1'b0;
    postFollow    = 1'b0;
    postGel       = '0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_gel", 32'({bus.g, bus.e, bus.l}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    applyStimulus(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);
    idleGap(2);
    applyStimulus(8'h3C, 8'h3D, 0, 0, 1'b0, 1'b0);
    idleGap(2);
    applyStimulus(8'hFF, 8'hFF, 4, 3, 1'b0, 1'b0);
    idleGap(2);
    applyStimulus(8'h80, 8'h7F, 0, 0, 1'b0, 1'b0);
    idleGap(1);
    ra = {1'b1, 7'($urandom)};
    rb = {1'b0, 7'($urandom)};
    applyStimulus(ra, rb, 0, 0, 1'b0, 1'b0);
    idleGap(2);
    applyStimulus(8'h12, 8'h34, 0, 0, 1'b0, 1'b1);
    applyStimulus(8'h56, 8'h56, 0, 0, 1'b1, 1'b0);
    idleGap(3);

    bus.start = 1'b1;
    @(posedge clk) #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit     = 1'($urandom);
      bus.b_bit     = 1'($urandom);
      @(posedge clk) #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_done", 32'(bus.done), 32'd0);
    checkOutput("midreset_gel", 32'({bus.g, bus.e, bus.l}), 32'd0);
    bus.bit_valid = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
    applyStimulus(8'hC3, 8'hC3, 0, 0, 1'b0, 1'b0);
    idleGap(2);

    for (int n = 0; n < 40; n++) begin
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) idleGap($urandom_range(1, 3));
      applyStimulus(ra, rb, $urandom_range(0, WIDTH - 1), $urandom_range(1, 4), b2b,
                    1'($urandom));
    end

    for (int k = 0; k < 60 && (sbq.size() > 0 || postPending); k++) @(posedge clk);
    @(posedge clk) #1;
    if (sbq.size() != 0) checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
